// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
//
// Per-output-port packet arbiter for the 5-port NoC router.
//
// Each input port's LBDR unit raises req[i] when its head flit wants this
// output. The arbiter picks one input in round-robin order and grants it the
// output. It then holds that grant as a wormhole lock from the HEADER flit to
// the TAIL flit. While the lock is held, the arbiter drives the crossbar select
// and pops the owner's FIFO.
//
// Flit id encoding: HEADER = 3'b001, TAIL = 3'b100. Any other code is treated
// as a payload flit.
//
// Optional feature macro: ARB_WATCHDOG_EN
//   defined   : a lock that makes no progress for TIMEOUT_CYC cycles is broken,
//               and timeout_err is set. timeout_err stays set until reset.
//   undefined : there is no watchdog, a lock is held for as long as needed,
//               and timeout_err is tied to 0.
//
// Ports
//   clk         in   router clock, rising edge
//   rst         in   asynchronous, active-low reset
//   req         in   [NUM_REQ]            LBDR request bit for this output, per input
//   valid       in   [NUM_REQ]            input FIFO not-empty, per input
//   flit_id     in   [NUM_REQ*FLIT_ID_W]  head flit id; input i at [i*FLIT_ID_W +: FLIT_ID_W]
//   out_ready   in   downstream can accept a flit this cycle
//   grant       out  [NUM_REQ]  registered one-hot owner of the output
//   xbar_sel    out  [SEL_W]    registered owner index (0 when idle)
//   rd_en       out  [NUM_REQ]  combinational FIFO pop, one-hot or 0
//   out_valid   out  combinational, a flit is presented downstream
//   busy        out  registered, the output is locked to an owner
//   timeout_err out  sticky watchdog flag (0 without ARB_WATCHDOG_EN)

module noc_output_arbiter #(
    parameter int NUM_REQ     = 5,
    parameter int SEL_W       = 3,
    parameter int FLIT_ID_W   = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             valid,
    input  logic [NUM_REQ*FLIT_ID_W-1:0]   flit_id,
    input  logic                           out_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [SEL_W-1:0]               xbar_sel,
    output logic [NUM_REQ-1:0]             rd_en,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam logic [FLIT_ID_W-1:0] FLIT_HEADER = FLIT_ID_W'(3'b001);
    localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = FLIT_ID_W'(3'b100);

    // Reject parameter sets that cannot work at elaboration time.
    if (SEL_W < $clog2(NUM_REQ) || TIMEOUT_CYC < 2) begin : g_param_check
        $error("noc_output_arbiter: SEL_W too narrow or TIMEOUT_CYC < 2");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state, state_nx;
    logic [NUM_REQ-1:0]     grant_nx;
    logic [SEL_W-1:0]       sel_nx;
    logic [SEL_W-1:0]       rr_ptr, rr_nx;

    logic [FLIT_ID_W-1:0]   fid [NUM_REQ];
    logic [NUM_REQ-1:0]     cand;
    logic                   found;
    logic [SEL_W-1:0]       winner;
    logic [SEL_W-1:0]       scan_idx;
    logic                   owner_valid;
    logic                   owner_tail;
    logic                   xfer;

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0]        wd_cnt, wd_nx;
    logic                   terr_q, terr_nx;

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Only a HEADER flit can open a new packet. This stops a stray payload or
    // tail flit from grabbing the output.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cand
        assign fid[i]  = flit_id[i*FLIT_ID_W +: FLIT_ID_W];
        assign cand[i] = req[i] & valid[i] & (fid[i] == FLIT_HEADER);
    end

    // Search starts one past the last owner. The previous owner therefore gets
    // the lowest priority in the next arbitration.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = SEL_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && cand[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // While the output is locked, xbar_sel names the owner. req[owner] is
    // deliberately ignored.
    assign owner_valid = valid[xbar_sel];
    assign owner_tail  = (fid[xbar_sel] == FLIT_TAIL);
    assign busy        = (state == LOCKED);

    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        sel_nx    = xbar_sel;
        rr_nx     = rr_ptr;
        rd_en     = '0;
        out_valid = 1'b0;
        xfer      = 1'b0;
`ifdef ARB_WATCHDOG_EN
        wd_nx     = wd_cnt;
        terr_nx   = terr_q;
`endif
        case (state)
            IDLE: begin
                // Arbitration only. The first pop happens in the next cycle.
                if (found) begin
                    state_nx = LOCKED;
                    grant_nx = NUM_REQ'(1) << winner;
                    sel_nx   = winner;
                end
`ifdef ARB_WATCHDOG_EN
                wd_nx = '0;
`endif
            end
            LOCKED: begin
                out_valid = owner_valid;
                xfer      = owner_valid & out_ready;
                if (xfer) begin
                    rd_en = grant;
                end
                // On release, the owner becomes the round-robin reference.
                if (xfer && owner_tail) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    sel_nx   = '0;
                    rr_nx    = xbar_sel;
                end
`ifdef ARB_WATCHDOG_EN
                if (xfer) begin
                    wd_nx = '0;
                end else if (wd_cnt == WD_LIMIT) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    sel_nx   = '0;
                    rr_nx    = xbar_sel;
                    terr_nx  = 1'b1;
                    wd_nx    = '0;
                end else if (wd_cnt != '1) begin
                    wd_nx = wd_cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // An asynchronous reset drops any lock immediately. Because rd_en depends
    // on the LOCKED state, no pop is issued while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            xbar_sel <= '0;
            rr_ptr   <= SEL_W'(NUM_REQ - 1);
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            xbar_sel <= sel_nx;
            rr_ptr   <= rr_nx;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_cnt <= wd_nx;
            terr_q <= terr_nx;
        end
    end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter
//
// Self-checking bench for noc_output_arbiter. The test runs in this order:
// a directed vector table, hand-written round-robin, backpressure and
// watchdog sequences, and a randomized run checked against a packet-level
// reference model.

module tb_noc_output_arbiter;

    localparam int NUM_REQ     = 5;
    localparam int SEL_W       = 3;
    localparam int FW          = 3;
    localparam int TIMEOUT_CYC = 64;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;
    localparam logic [2:0] NONE    = 3'b000;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ-1:0]        valid = '0;
    logic [NUM_REQ*FW-1:0]     flit_id = '0;
    logic                      out_ready = 1'b0;
    logic [NUM_REQ-1:0]        grant;
    logic [SEL_W-1:0]          xbar_sel;
    logic [NUM_REQ-1:0]        rd_en;
    logic                      out_valid;
    logic                      busy;
    logic                      timeout_err;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    noc_output_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .SEL_W      (SEL_W),
        .FLIT_ID_W  (FW),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .valid      (valid),
        .flit_id    (flit_id),
        .out_ready  (out_ready),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .rd_en      (rd_en),
        .out_valid  (out_valid),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [4:0]  req;
        logic [4:0]  valid;
        logic [14:0] fid;
        logic        ready;
        logic [4:0]  exp_grant;
        logic [2:0]  exp_sel;
        logic [4:0]  exp_rd;
        logic        exp_ov;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [14:0] pack_fid(input logic [2:0] f0, f1, f2, f3, f4);
        return {f4, f3, f2, f1, f0};
    endfunction

    function automatic vec_t mk(input logic [4:0] r, v, input logic [14:0] f,
                                input logic rdy, input logic [4:0] eg,
                                input logic [2:0] es, input logic [4:0] erd,
                                input logic eov, eb);
        vec_t x;
        x.req = r; x.valid = v; x.fid = f; x.ready = rdy;
        x.exp_grant = eg; x.exp_sel = es; x.exp_rd = erd;
        x.exp_ov = eov; x.exp_busy = eb;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        chk_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] r, v, input logic [14:0] f, input logic rdy);
        req       = r;
        valid     = v;
        flit_id   = f;
        out_ready = rdy;
    endtask

    task automatic check_all(input logic [4:0] eg, input logic [2:0] es,
                             input logic [4:0] erd, input logic eov, eb, eterr);
        checkOutput("grant",       32'(grant),       32'(eg));
        checkOutput("xbar_sel",    32'(xbar_sel),    32'(es));
        checkOutput("rd_en",       32'(rd_en),       32'(erd));
        checkOutput("out_valid",   32'(out_valid),   32'(eov));
        checkOutput("busy",        32'(busy),        32'(eb));
        checkOutput("timeout_err", 32'(timeout_err), 32'(eterr));
    endtask

    // Inputs change 1 time unit after the rising edge. Outputs are sampled 4
    // time units later, which is half a period away from either edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Packet-level reference model state: the owner (-1 when idle), the last
    // released owner, and the number of consecutive stalled locked cycles.
    int m_owner = -1;
    int m_rr    = NUM_REQ - 1;
    int m_stall = 0;
    bit m_terr  = 1'b0;

    task automatic model_reset();
        m_owner = -1;
        m_rr    = NUM_REQ - 1;
        m_stall = 0;
        m_terr  = 1'b0;
    endtask

    task automatic model_cycle();
        logic [4:0] eg, erd;
        logic [2:0] es;
        logic       eov, eb, et;
        int         n_owner, n_rr, n_stall;
        bit         n_terr;
        logic [2:0] f;
        eg = '0; erd = '0; es = '0; eov = 1'b0; eb = 1'b0; et = m_terr;
        n_owner = m_owner; n_rr = m_rr; n_stall = m_stall; n_terr = m_terr;
        if (m_owner < 0) begin
            n_stall = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                int idx;
                idx = (m_rr + k) % NUM_REQ;
                f = flit_id[idx*FW +: FW];
                if (n_owner < 0 && req[idx] && valid[idx] && f == HEADER) begin
                    n_owner = idx;
                end
            end
        end else begin
            eg  = 5'(1 << m_owner);
            es  = 3'(m_owner);
            eb  = 1'b1;
            eov = valid[m_owner];
            f   = flit_id[m_owner*FW +: FW];
            if (valid[m_owner] && out_ready) begin
                erd     = 5'(1 << m_owner);
                n_stall = 0;
                if (f == TAIL) begin
                    n_owner = -1;
                    n_rr    = m_owner;
                end
            end else begin
                n_stall = m_stall + 1;
`ifdef ARB_WATCHDOG_EN
                if (n_stall == TIMEOUT_CYC) begin
                    n_owner = -1;
                    n_rr    = m_owner;
                    n_terr  = 1'b1;
                    n_stall = 0;
                end
`endif
            end
        end
        #4;
        check_all(eg, es, erd, eov, eb, et);
        m_owner = n_owner; m_rr = n_rr; m_stall = n_stall; m_terr = n_terr;
    endtask

    initial begin
        int order [6];
        logic [14:0] f_all_h;
        logic [14:0] f;
        logic [4:0]  v;

        order = '{0, 1, 2, 3, 4, 0};
        f_all_h = pack_fid(HEADER, HEADER, HEADER, HEADER, HEADER);

        vecs[0]  = mk(5'b00010, 5'b00010, pack_fid(NONE, HEADER, NONE, NONE, NONE), 1'b1, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0);
        vecs[1]  = mk(5'b00010, 5'b00010, pack_fid(NONE, HEADER, NONE, NONE, NONE), 1'b1, 5'b00010, 3'd1, 5'b00010, 1'b1, 1'b1);
        vecs[2]  = mk(5'b00010, 5'b00010, pack_fid(NONE, PAYLOAD, NONE, NONE, NONE), 1'b1, 5'b00010, 3'd1, 5'b00010, 1'b1, 1'b1);
        vecs[3]  = mk(5'b00010, 5'b00010, pack_fid(NONE, TAIL, NONE, NONE, NONE), 1'b1, 5'b00010, 3'd1, 5'b00010, 1'b1, 1'b1);
        vecs[4]  = mk(5'b00000, 5'b00000, pack_fid(NONE, NONE, NONE, NONE, NONE), 1'b1, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0);
        vecs[5]  = mk(5'b00101, 5'b00101, pack_fid(HEADER, NONE, HEADER, NONE, NONE), 1'b1, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0);
        vecs[6]  = mk(5'b00101, 5'b00101, pack_fid(HEADER, NONE, HEADER, NONE, NONE), 1'b0, 5'b00100, 3'd2, 5'b00000, 1'b1, 1'b1);
        vecs[7]  = mk(5'b00101, 5'b00101, pack_fid(HEADER, NONE, HEADER, NONE, NONE), 1'b1, 5'b00100, 3'd2, 5'b00100, 1'b1, 1'b1);
        vecs[8]  = mk(5'b00101, 5'b00001, pack_fid(HEADER, NONE, PAYLOAD, NONE, NONE), 1'b1, 5'b00100, 3'd2, 5'b00000, 1'b0, 1'b1);
        vecs[9]  = mk(5'b00101, 5'b00101, pack_fid(HEADER, NONE, TAIL, NONE, NONE), 1'b1, 5'b00100, 3'd2, 5'b00100, 1'b1, 1'b1);
        vecs[10] = mk(5'b00001, 5'b00001, pack_fid(HEADER, NONE, NONE, NONE, NONE), 1'b1, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0);
        vecs[11] = mk(5'b00001, 5'b00001, pack_fid(HEADER, NONE, NONE, NONE, NONE), 1'b0, 5'b00001, 3'd0, 5'b00000, 1'b1, 1'b1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // Directed table: single packet, then priority after release and
        // lock retention against a competing header.
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            applyStimulus(vecs[i].req, vecs[i].valid, vecs[i].fid, vecs[i].ready);
            #4;
            check_all(vecs[i].exp_grant, vecs[i].exp_sel, vecs[i].exp_rd,
                      vecs[i].exp_ov, vecs[i].exp_busy, 1'b0);
        end

        // Asynchronous reset while input 0 holds the lock.
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        check_all(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b1;
        applyStimulus(5'b0, 5'b0, 15'b0, 1'b0);

        // Round-robin with all inputs requesting 2-flit packets back to back.
        for (int p = 0; p < 6; p++) begin
            next_cycle();
            applyStimulus(5'b11111, 5'b11111, f_all_h, 1'b1);
            #4;
            check_all(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b0);
            next_cycle();
            applyStimulus(5'b11111, 5'b11111, f_all_h, 1'b1);
            #4;
            check_all(5'(1 << order[p]), 3'(order[p]), 5'(1 << order[p]), 1'b1, 1'b1, 1'b0);
            next_cycle();
            f = f_all_h;
            f[order[p]*FW +: FW] = TAIL;
            applyStimulus(5'b11111, 5'b11111, f, 1'b1);
            #4;
            check_all(5'(1 << order[p]), 3'(order[p]), 5'(1 << order[p]), 1'b1, 1'b1, 1'b0);
        end

        // Backpressure on input 3 mid-packet.
        next_cycle();
        applyStimulus(5'b01000, 5'b01000, pack_fid(NONE, NONE, NONE, HEADER, NONE), 1'b1);
        #4;
        check_all(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(5'b01000, 5'b01000, pack_fid(NONE, NONE, NONE, HEADER, NONE), 1'b1);
        #4;
        check_all(5'b01000, 3'd3, 5'b01000, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            v = (k % 3 == 2) ? 5'b00000 : 5'b01000;
            applyStimulus(5'b01000, v, pack_fid(NONE, NONE, NONE, PAYLOAD, NONE), 1'b0);
            #4;
            check_all(5'b01000, 3'd3, 5'b0, v[3], 1'b1, 1'b0);
        end
        next_cycle();
        applyStimulus(5'b01000, 5'b01000, pack_fid(NONE, NONE, NONE, PAYLOAD, NONE), 1'b1);
        #4;
        check_all(5'b01000, 3'd3, 5'b01000, 1'b1, 1'b1, 1'b0);
        next_cycle();
        applyStimulus(5'b01000, 5'b01000, pack_fid(NONE, NONE, NONE, TAIL, NONE), 1'b1);
        #4;
        check_all(5'b01000, 3'd3, 5'b01000, 1'b1, 1'b1, 1'b0);
        next_cycle();
        applyStimulus(5'b0, 5'b0, 15'b0, 1'b1);
        #4;
        check_all(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b0);

        // Owner 4 goes empty for 70 cycles after its lock.
        next_cycle();
        applyStimulus(5'b10000, 5'b10000, pack_fid(NONE, NONE, NONE, NONE, HEADER), 1'b1);
        #4;
        check_all(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 70; k++) begin
            next_cycle();
            applyStimulus(5'b10000, 5'b00000, pack_fid(NONE, NONE, NONE, NONE, HEADER), 1'b1);
            #4;
`ifdef ARB_WATCHDOG_EN
            if (k <= TIMEOUT_CYC)
                check_all(5'b10000, 3'd4, 5'b0, 1'b0, 1'b1, 1'b0);
            else
                check_all(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b1);
`else
            check_all(5'b10000, 3'd4, 5'b0, 1'b0, 1'b1, 1'b0);
`endif
        end

        // Reset clears everything, including a sticky timeout flag.
        next_cycle();
        rst = 1'b0;
        #2;
        check_all(5'b0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        rst = 1'b1;
        applyStimulus(5'b0, 5'b0, 15'b0, 1'b0);
        model_reset();

        // Randomized traffic checked against the reference model.
        for (int c = 0; c < 1500; c++) begin
            logic [14:0] rf;
            next_cycle();
            for (int i = 0; i < NUM_REQ; i++) begin
                case ($urandom_range(0, 3))
                    0, 1:    rf[i*FW +: FW] = HEADER;
                    2:       rf[i*FW +: FW] = PAYLOAD;
                    default: rf[i*FW +: FW] = TAIL;
                endcase
            end
            applyStimulus(5'($urandom), 5'($urandom | $urandom), rf, $urandom_range(0, 3) != 0);
            model_cycle();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
